uart_fifo_core: RTL and testbench

UART_FIFO_CORE -- requirements
Module: uart_fifo_core

---
 rtl/uart_fifo_core.sv | 367 ++++++++++++++++++++++++++++++++++++
 tb/tb_uart_fifo_core.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_core.sv
// UART with TX/RX FIFOs; optional even parity when UART_PARITY_EN is defined.
// Latency: TX serial starts 2 cycles after push into an idle core; RX byte visible the cycle after stop sample.
// Backpressure: TX push dropped when o_TX_Full; RX byte dropped (o_Overrun) when FIFO full and not popped.

module uart_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         i_Clock,
    input  logic         i_Rst_L,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_rdy,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    // A push into a full FIFO only fits when the head leaves in the same cycle.
    assign pop_ok  = pop_rdy && !empty;
    assign push_ok = push_vld && (!full || pop_ok);
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge i_Clock) begin
        if (push_ok) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module uart_fifo_core #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    parameter int TX_DEPTH  = 8,
    parameter int RX_DEPTH  = 8
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_L,
    input  logic [15:0]          i_Clk_Div,
    input  logic                 i_TX_Wr,
    input  logic [DATA_BITS-1:0] i_TX_Byte,
    output logic                 o_TX_Full,
    output logic                 o_TX_Serial,
    output logic                 o_TX_Active,
    input  logic                 i_RX_Serial,
    input  logic                 i_RX_Rd,
    output logic [DATA_BITS-1:0] o_RX_Byte,
    output logic                 o_RX_Empty,
    output logic                 o_RX_Irq,
    output logic                 o_Frame_Err,
    output logic                 o_Overrun,
    output logic                 o_Parity_Err,
    input  logic                 i_Err_Clr
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    logic [15:0] div_eff;
    assign div_eff = (i_Clk_Div < 16'd4) ? 16'd4 : i_Clk_Div;

    // ---------------- TX ----------------
    logic                 tx_full;
    logic                 tx_empty;
    logic [DATA_BITS-1:0] tx_head;
    logic                 tx_load;
    logic                 tx_tick;
    logic [2:0]           tx_state;
    logic [15:0]          tx_cnt;
    logic [15:0]          tx_period;
    logic [DATA_BITS-1:0] tx_shreg;
    logic                 tx_par;
    logic [2:0]           tx_bit_idx;
    logic                 tx_stop_idx;

    assign o_TX_Full = tx_full;
    assign tx_tick   = (tx_cnt == tx_period - 16'd1);
    // Loading at the end of the last stop bit gives back-to-back frames with no idle gap.
    assign tx_load   = !tx_empty && ((tx_state == S_IDLE) ||
                       ((tx_state == S_STOP) && tx_tick && (tx_stop_idx == LAST_STOP)));

    uart_sync_fifo #(.W(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .i_Clock  (i_Clock),
        .i_Rst_L  (i_Rst_L),
        .push_vld (i_TX_Wr && !tx_full),
        .push_dat (i_TX_Byte),
        .pop_rdy  (tx_load),
        .head_dat (tx_head),
        .full     (tx_full),
        .empty    (tx_empty)
    );

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            tx_state    <= S_IDLE;
            o_TX_Serial <= 1'b1;
            o_TX_Active <= 1'b0;
            tx_cnt      <= '0;
            tx_period   <= 16'd4;
            tx_shreg    <= '0;
            tx_par      <= 1'b0;
            tx_bit_idx  <= '0;
            tx_stop_idx <= 1'b0;
        end else if (tx_load) begin
            tx_state    <= S_START;
            o_TX_Serial <= 1'b0;
            o_TX_Active <= 1'b1;
            tx_cnt      <= '0;
            tx_period   <= div_eff;
            tx_shreg    <= tx_head;
            tx_par      <= ^tx_head;
        end else begin
            case (tx_state)
                S_IDLE: begin
                    o_TX_Serial <= 1'b1;
                    o_TX_Active <= 1'b0;
                end
                S_START: begin
                    if (tx_tick) begin
                        tx_cnt      <= '0;
                        tx_state    <= S_DATA;
                        o_TX_Serial <= tx_shreg[0];
                        tx_shreg    <= tx_shreg >> 1;
                        tx_bit_idx  <= '0;
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (tx_tick) begin
                        tx_cnt <= '0;
                        if (tx_bit_idx == LAST_BIT) begin
`ifdef UART_PARITY_EN
                            tx_state    <= S_PARITY;
                            o_TX_Serial <= tx_par;
`else
                            tx_state    <= S_STOP;
                            o_TX_Serial <= 1'b1;
                            tx_stop_idx <= 1'b0;
`endif
                        end else begin
                            tx_bit_idx  <= tx_bit_idx + 3'd1;
                            o_TX_Serial <= tx_shreg[0];
                            tx_shreg    <= tx_shreg >> 1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: begin
                    if (tx_tick) begin
                        tx_cnt      <= '0;
                        tx_state    <= S_STOP;
                        o_TX_Serial <= 1'b1;
                        tx_stop_idx <= 1'b0;
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
`endif
                S_STOP: begin
                    if (tx_tick) begin
                        tx_cnt <= '0;
                        if (tx_stop_idx == LAST_STOP) begin
                            tx_state    <= S_IDLE;
                            o_TX_Serial <= 1'b1;
                            o_TX_Active <= 1'b0;
                        end else begin
                            tx_stop_idx <= tx_stop_idx + 1'b1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                default: begin
                    tx_state    <= S_IDLE;
                    o_TX_Serial <= 1'b1;
                    o_TX_Active <= 1'b0;
                end
            endcase
        end
    end

    // ---------------- RX ----------------
    logic                 rx_meta;
    logic                 rx_s;
    logic [2:0]           rx_state;
    logic [15:0]          rx_cnt;
    logic [15:0]          rx_period;
    logic [15:0]          rx_half;
    logic                 rx_tick;
    logic [DATA_BITS-1:0] rx_shreg;
    logic [2:0]           rx_bit_idx;
    logic                 rx_par_ok;
    logic                 rx_push_req;
    logic                 rx_full;
    logic                 rx_empty;
    logic                 rx_pop_ok;
    logic [DATA_BITS-1:0] rx_head;
    logic                 frame_evt;
    logic                 ovr_evt;
    logic                 par_evt;

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_RX_Serial;
            rx_s    <= rx_meta;
        end
    end

    assign rx_half = (rx_period - 16'd1) >> 1;
    assign rx_tick = (rx_cnt == rx_period - 16'd1);

`ifdef UART_PARITY_EN
    logic rx_par_bad;
    assign rx_par_ok = !rx_par_bad;
    assign par_evt   = (rx_state == S_PARITY) && rx_tick && (^{rx_shreg, rx_s});
`else
    assign rx_par_ok = 1'b1;
    assign par_evt   = 1'b0;
`endif

    assign frame_evt   = (rx_state == S_STOP) && rx_tick && !rx_s;
    assign rx_push_req = (rx_state == S_STOP) && rx_tick && rx_s && rx_par_ok;
    assign rx_pop_ok   = i_RX_Rd && !rx_empty;
    assign ovr_evt     = rx_push_req && rx_full && !rx_pop_ok;

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rx_state   <= S_IDLE;
            rx_cnt     <= '0;
            rx_period  <= 16'd4;
            rx_shreg   <= '0;
            rx_bit_idx <= '0;
`ifdef UART_PARITY_EN
            rx_par_bad <= 1'b0;
`endif
        end else begin
            case (rx_state)
                S_IDLE: begin
                    if (!rx_s) begin
                        rx_state  <= S_START;
                        rx_period <= div_eff;
                        rx_cnt    <= '0;
                    end
                end
                S_START: begin
                    // Mid-bit check filters glitches; later samples land one period apart.
                    if (rx_cnt == rx_half) begin
                        rx_cnt     <= '0;
                        rx_bit_idx <= '0;
                        rx_state   <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (rx_tick) begin
                        rx_cnt   <= '0;
                        rx_shreg <= {rx_s, rx_shreg[DATA_BITS-1:1]};
                        if (rx_bit_idx == LAST_BIT) begin
`ifdef UART_PARITY_EN
                            rx_state <= S_PARITY;
`else
                            rx_state <= S_STOP;
`endif
                        end else begin
                            rx_bit_idx <= rx_bit_idx + 3'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: begin
                    if (rx_tick) begin
                        rx_cnt     <= '0;
                        rx_par_bad <= ^{rx_shreg, rx_s};
                        rx_state   <= S_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
`endif
                S_STOP: begin
                    if (rx_tick) begin
                        rx_cnt   <= '0;
                        rx_state <= S_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end

    uart_sync_fifo #(.W(DATA_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .i_Clock  (i_Clock),
        .i_Rst_L  (i_Rst_L),
        .push_vld (rx_push_req),
        .push_dat (rx_shreg),
        .pop_rdy  (i_RX_Rd),
        .head_dat (rx_head),
        .full     (rx_full),
        .empty    (rx_empty)
    );

    assign o_RX_Empty = rx_empty;
    assign o_RX_Irq   = !rx_empty;
    assign o_RX_Byte  = rx_empty ? '0 : rx_head;

    // Sticky flags: a set event outranks a same-cycle clear.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_Frame_Err <= 1'b0;
            o_Overrun   <= 1'b0;
        end else begin
            o_Frame_Err <= frame_evt | (o_Frame_Err & !i_Err_Clr);
            o_Overrun   <= ovr_evt   | (o_Overrun   & !i_Err_Clr);
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) o_Parity_Err <= 1'b0;
        else          o_Parity_Err <= par_evt | (o_Parity_Err & !i_Err_Clr);
    end
`else
    assign o_Parity_Err = par_evt;
`endif
endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed bench for uart_fifo_core with TX/RX scoreboards; honours UART_PARITY_EN.
module tb_uart_fifo_core;
`ifdef UART_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME_BITS = 1 + 8 + PAR + 1;

    logic        i_Clock = 1'b0;
    logic        i_Rst_L = 1'b0;
    logic [15:0] i_Clk_Div = 16'd16;
    logic        i_TX_Wr = 1'b0;
    logic [7:0]  i_TX_Byte = '0;
    logic        o_TX_Full, o_TX_Serial, o_TX_Active;
    logic        i_RX_Serial;
    logic        i_RX_Rd = 1'b0;
    logic [7:0]  o_RX_Byte;
    logic        o_RX_Empty, o_RX_Irq, o_Frame_Err, o_Overrun, o_Parity_Err;
    logic        i_Err_Clr = 1'b0;
    logic        loop_en = 1'b0;
    logic        rx_drv = 1'b1;

    assign i_RX_Serial = loop_en ? o_TX_Serial : rx_drv;

    uart_fifo_core dut (
        .i_Clock(i_Clock), .i_Rst_L(i_Rst_L), .i_Clk_Div(i_Clk_Div),
        .i_TX_Wr(i_TX_Wr), .i_TX_Byte(i_TX_Byte), .o_TX_Full(o_TX_Full),
        .o_TX_Serial(o_TX_Serial), .o_TX_Active(o_TX_Active),
        .i_RX_Serial(i_RX_Serial), .i_RX_Rd(i_RX_Rd), .o_RX_Byte(o_RX_Byte),
        .o_RX_Empty(o_RX_Empty), .o_RX_Irq(o_RX_Irq), .o_Frame_Err(o_Frame_Err),
        .o_Overrun(o_Overrun), .o_Parity_Err(o_Parity_Err), .i_Err_Clr(i_Err_Clr)
    );

    always #5 i_Clock = ~i_Clock;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_Clock);
        #1;
    endtask

    // ---------------- TX scoreboard/monitor ----------------
    logic [7:0]  tx_exp_q[$];
    logic [7:0]  rx_exp_q[$];
    bit          mon_en = 1'b0;
    int          cur_div = 16;
    int          mon_c = 0;
    int          mon_run = 0;
    int          last_run = 0;
    logic [15:0] mon_vec = '0;
    logic [7:0]  mon_byte = '0;

    function automatic logic exp_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        if (PAR == 1 && i == 9) return ^b;
        return 1'b1;
    endfunction

    always @(posedge i_Clock) begin
        #1;
        if (mon_en) begin
            if (o_TX_Active) begin
                if (mon_c == 0) begin
                    check("tx_frame_expected", 32'(tx_exp_q.size() > 0), 32'd1);
                    mon_byte = (tx_exp_q.size() > 0) ? tx_exp_q.pop_front() : 8'h00;
                end
                mon_vec = {mon_vec[14:0], o_TX_Serial};
                if (mon_c % cur_div == cur_div - 1) begin
                    logic [15:0] mask;
                    mask = 16'((32'h1 << cur_div) - 1);
                    check("tx_bit", 32'(mon_vec & mask),
                          32'(exp_bit(mon_byte, mon_c / cur_div) ? mask : 16'h0));
                end
                mon_run++;
                mon_c = (mon_c + 1 == FRAME_BITS * cur_div) ? 0 : mon_c + 1;
            end else if (mon_run != 0) begin
                check("tx_frame_align", 32'(mon_c), 32'd0);
                last_run = mon_run;
                mon_run = 0;
                mon_c = 0;
            end
        end
    end

    task automatic push_tx(input logic [7:0] b, input bit expect_accept);
        if (expect_accept) tx_exp_q.push_back(b);
        i_TX_Wr = 1'b1;
        i_TX_Byte = b;
        tick();
        i_TX_Wr = 1'b0;
    endtask

    task automatic wait_active(input logic lvl, input int bound, input string tag);
        int n = 0;
        while (o_TX_Active !== lvl && n < bound) begin
            tick();
            n++;
        end
        check(tag, 32'(o_TX_Active), 32'(lvl));
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_v, input logic par_flip, input int div);
        logic [11:0] bits;
        int nb;
        bits = '0;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = b[i];
        nb = 9;
        if (PAR == 1) begin
            bits[9] = (^b) ^ par_flip;
            nb = 10;
        end
        bits[nb] = stop_v;
        nb++;
        for (int i = 0; i < nb; i++) begin
            rx_drv = bits[i];
            repeat (div) tick();
        end
        rx_drv = 1'b1;
        repeat (2 * div) tick();
    endtask

    task automatic pop_rx(input string tag);
        logic [7:0] e;
        e = (rx_exp_q.size() > 0) ? rx_exp_q.pop_front() : 8'hxx;
        check({tag, "_irq"}, 32'(o_RX_Irq), 32'd1);
        check({tag, "_byte"}, 32'(o_RX_Byte), 32'(e));
        i_RX_Rd = 1'b1;
        tick();
        i_RX_Rd = 1'b0;
    endtask

    task automatic clear_errs();
        i_Err_Clr = 1'b1;
        tick();
        i_Err_Clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        check("rst_tx_serial", 32'(o_TX_Serial), 32'd1);
        check("rst_tx_active", 32'(o_TX_Active), 32'd0);
        check("rst_tx_full", 32'(o_TX_Full), 32'd0);
        check("rst_rx_empty", 32'(o_RX_Empty), 32'd1);
        check("rst_rx_irq", 32'(o_RX_Irq), 32'd0);
        check("rst_rx_byte", 32'(o_RX_Byte), 32'd0);
        check("rst_errs", 32'({o_Frame_Err, o_Overrun, o_Parity_Err}), 32'd0);
        i_Rst_L = 1'b1;
        repeat (2) tick();

        // Single frame, div 16
        mon_en = 1'b1;
        cur_div = 16; i_Clk_Div = 16'd16;
        push_tx(8'hA5, 1'b1);
        wait_active(1'b1, 10, "a5_start");
        wait_active(1'b0, 400, "a5_end");
        tick();
        check("a5_active_len", 32'(last_run), 32'(FRAME_BITS * 16));
        check("a5_idle_high", 32'(o_TX_Serial), 32'd1);

        // Three back-to-back frames with no idle gap
        push_tx(8'h01, 1'b1);
        push_tx(8'h02, 1'b1);
        push_tx(8'h03, 1'b1);
        wait_active(1'b1, 10, "b2b_start");
        wait_active(1'b0, 1200, "b2b_end");
        tick();
        check("b2b_active_len", 32'(last_run), 32'(3 * FRAME_BITS * 16));

        // Divisor below 4 clamps to 4
        cur_div = 4; i_Clk_Div = 16'd1;
        push_tx(8'h5A, 1'b1);
        wait_active(1'b1, 10, "clamp_start");
        wait_active(1'b0, 200, "clamp_end");
        tick();
        check("clamp_active_len", 32'(last_run), 32'(FRAME_BITS * 4));

        // Fill TX FIFO while a frame holds the transmitter; 9th push is dropped
        i_Clk_Div = 16'd4;
        push_tx(8'h80, 1'b1);
        wait_active(1'b1, 10, "full_start");
        for (int i = 0; i < 9; i++) begin
            push_tx(8'(8'h10 + i), i < 8);
            check("tx_full_flag", 32'(o_TX_Full), 32'(i >= 7));
        end
        wait_active(1'b0, 1000, "full_end");
        tick();
        check("full_active_len", 32'(last_run), 32'(9 * FRAME_BITS * 4));
        check("full_sb_drained", 32'(tx_exp_q.size()), 32'd0);

        // Loopback, div 4
        loop_en = 1'b1;
        push_tx(8'h3C, 1'b1);
        rx_exp_q.push_back(8'h3C);
        for (int n = 0; n < 300 && !o_RX_Irq; n++) tick();
        pop_rx("loop");
        check("loop_empty", 32'(o_RX_Empty), 32'd1);
        wait_active(1'b0, 200, "loop_tx_end");
        repeat (4) tick();
        loop_en = 1'b0;

        // Direct RX frames, div 8
        i_Clk_Div = 16'd8;
        rx_exp_q.push_back(8'hC3);
        send_rx(8'hC3, 1'b1, 1'b0, 8);
        pop_rx("rx_c3");
        send_rx(8'h55, 1'b0, 1'b0, 8);
        check("ferr_set", 32'(o_Frame_Err), 32'd1);
        check("ferr_empty", 32'(o_RX_Empty), 32'd1);
        clear_errs();
        check("ferr_clr", 32'(o_Frame_Err), 32'd0);

        // Overrun: 9 frames into depth 8 without reads
        for (int i = 0; i < 9; i++) begin
            if (i < 8) rx_exp_q.push_back(8'(8'hA0 + 3 * i));
            send_rx(8'(8'hA0 + 3 * i), 1'b1, 1'b0, 8);
        end
        check("ovr_set", 32'(o_Overrun), 32'd1);
        for (int i = 0; i < 8; i++) pop_rx("ovr_order");
        check("ovr_drained", 32'(o_RX_Empty), 32'd1);
        i_RX_Rd = 1'b1;
        tick();
        i_RX_Rd = 1'b0;
        check("rd_empty_ignored", 32'({o_RX_Empty, o_RX_Byte}), 32'h100);
        clear_errs();
        check("ovr_clr", 32'(o_Overrun), 32'd0);

`ifdef UART_PARITY_EN
        send_rx(8'h07, 1'b1, 1'b1, 8);
        check("perr_set", 32'(o_Parity_Err), 32'd1);
        check("perr_no_push", 32'(o_RX_Empty), 32'd1);
        rx_exp_q.push_back(8'h07);
        send_rx(8'h07, 1'b1, 1'b0, 8);
        pop_rx("par_good");
        clear_errs();
        check("perr_clr", 32'(o_Parity_Err), 32'd0);
`else
        send_rx(8'h07, 1'b1, 1'b0, 8);
        check("perr_tied", 32'(o_Parity_Err), 32'd0);
        rx_exp_q.push_back(8'h07);
        pop_rx("rx_07");
`endif

        // Asynchronous reset during TX data bit 3
        cur_div = 16; i_Clk_Div = 16'd16;
        push_tx(8'h00, 1'b1);
        wait_active(1'b1, 10, "rst_tx_start");
        repeat (4 * 16 + 8) tick();
        check("pre_rst_serial", 32'(o_TX_Serial), 32'd0);
        mon_en = 1'b0;
        i_Rst_L = 1'b0;
        #1;
        check("async_rst_serial", 32'(o_TX_Serial), 32'd1);
        check("async_rst_active", 32'(o_TX_Active), 32'd0);
        tx_exp_q.delete();
        mon_c = 0; mon_run = 0;
        tick();
        i_Rst_L = 1'b1;
        repeat (5) tick();
        check("post_rst_idle", 32'({o_TX_Active, o_TX_Serial, o_RX_Empty}), 32'b011);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
